genesis_pad_emulator: RTL
=========================

// Module: genesis_pad_emulator
// PURPOSE
//  Device-side Genesis controller emulator: drives the six pad lines in response to
//  the console's SELECT (TH) line, presenting a 6-button, 3-button or MasterSystem pad.
//  Button state comes from an on-board source (USB/PS2 bridge, test logic).
//  It is the other end of the host-side pad reader and must interoperate with it
//  in loopback, one clock domain, SELECT toggling every cycle.
// PARAMETERS
//  SYNC_STAGES     2      iSELECT synchronizer depth; 0 = same-domain, no synchronizer
//  TIMEOUT_CYCLES  75000  idle cycles without a SELECT edge before the 6-button phase resets (1.5 ms @ 50 MHz)
// PORTS
//  iCLK      in   1   system clock
//  iRESET    in   1   synchronous reset, active high
//  iMODE     in   2   0 MasterSystem, 1 3-button, 2 6-button, 3 disconnected
//  iBUTTONS  in   12  {Z,Y,X,M,S,C,B,A,U,D,L,R}, 1 = pressed
//  iSELECT   in   1   TH/SELECT from console
//  oPAD      out  6   {C/Start,B/A,Up/Z,Down/Y,Left/X,Right/Mode}, 0 = pressed/low
//  oPHASE    out  2   current 6-button cycle count (debug)
// BEHAVIOUR
//  - Reset: oPAD=6'h3F, oPHASE=0, timeout counter=0, sync/history flops=1, button reg=0.
//  - Buttons registered every cycle (btn_q): 1-cycle latency to oPAD.
//  - sel = iSELECT after SYNC_STAGES flops (direct when 0); sel_q = sel delayed 1 cycle.
//  - oPAD is combinational from sel, phase cnt (2-bit), btn_q, iMODE; no extra latency
//    beyond the synchronizer.
//  - cnt increments (mod 4) on sel rising edge (sel=1, sel_q=0) only when iMODE==2;
//    otherwise cnt held 0. Falling edges do not change cnt. oPHASE = cnt.
//  - Output table, iMODE==2 (before inversion to active-low):
//      sel=1, cnt 0..2 : {C,B,U,D,L,R}
//      sel=1, cnt 3    : {C,B,Z,Y,X,M}
//      sel=0, cnt 0..1 : {S,A,U,D,0,0}   (L/R lines driven low)
//      sel=0, cnt 2    : {S,A,0,0,0,0}   (all D-pad lines low = 6-button ID)
//      sel=0, cnt 3    : {S,A,1,1,1,1}   (all D-pad lines high)
//    Pressed buttons drive 0; forced 0/1 entries drive the line level directly.
//  - iMODE==1: cnt-0 rows only. iMODE==0: {C,B,U,D,L,R} regardless of sel
//    (B = button 1/TL, C = button 2/TR). iMODE==3: oPAD=6'h3F.
//  - Timeout: counter increments each cycle with no sel edge (either polarity), cleared on any
//    edge; reaching TIMEOUT_CYCLES sets cnt=0 and holds counter saturated until next edge.
//    Edge and timeout in same cycle: edge wins. Width = $clog2(TIMEOUT_CYCLES+1).
//  - iMODE change: cnt forced 0 same cycle for any mode != 2; returns to counting from 0.
//  - Reset mid-cycle: all state returns to reset values next edge; no partial phase kept.
// TESTING
//  1 iRESET=1 two cycles, any iSELECT/iBUTTONS -> oPAD=6'h3F, oPHASE=0.
//  2 SYNC_STAGES=0, iMODE=2, iBUTTONS=12'h810 (Z,A); sel H,L x4 -> highs 3F,3F,3F,37;
//    lows 2C,2C,20,2F; oPHASE 0,1,2,3 then wraps to 0.
//  3 Same setup, two low pulses then sel high for TIMEOUT_CYCLES -> oPHASE=0; next low gives 6'h2C, not 6'h20.
//  4 iMODE=1, 4 sel pulses, iBUTTONS=12'h810 -> every low 6'h2C, every high 6'h3F, oPHASE stays 0.
//  5 iMODE=0, iBUTTONS=12'h041 (C,R), sel toggling -> oPAD constant 6'h1E; iMODE=3 -> 6'h3F.
//  6 Loopback with host pad reader, iMODE=2, random iBUTTONS -> reader type=2 and decoded
//    == iBUTTONS within 16 cycles; iRESET at cnt=3 -> oPHASE=0, oPAD=6'h3F next cycle.

Source files
------------

// File: rtl/genesis_pad_emulator.sv
// Genesis controller emulator: answers console SELECT (TH) with 6-button,
// 3-button or MasterSystem pad levels built from a registered button set.
module genesis_pad_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 75000
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iBUTTONS,
    input  logic        iSELECT,
    output logic [5:0]  oPAD,
    output logic [1:0]  oPHASE
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TNEAR = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_SMS = 2'd0,
        MODE_3B  = 2'd1,
        MODE_6B  = 2'd2,
        MODE_OFF = 2'd3
    } mode_e;

    mode_e         mode;
    logic          sel;
    logic          selQ;
    logic          selEdge;
    logic          selRise;
    logic [11:0]   btnQ;
    logic [1:0]    cnt;
    logic [1:0]    cntEff;
    logic [TW-1:0] tmo;
    logic [5:0]    lvl;

    assign mode = mode_e'(iMODE);

    generate
        if (SYNC_STAGES == 0) begin : gNoSync
            assign sel = iSELECT;
        end else begin : gSync
            logic [SYNC_STAGES-1:0] syncQ;
            always_ff @(posedge iCLK) begin
                if (iRESET) begin
                    syncQ <= '1;
                end else begin
                    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                        syncQ[i] <= syncQ[i-1];
                    end
                    syncQ[0] <= iSELECT;
                end
            end
            assign sel = syncQ[SYNC_STAGES-1];
        end
    endgenerate

    assign selEdge = sel ^ selQ;
    assign selRise = sel & ~selQ;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            selQ <= 1'b1;
            btnQ <= '0;
            cnt  <= '0;
            tmo  <= '0;
        end else begin
            selQ <= sel;
            btnQ <= iBUTTONS;
            if (selEdge) begin
                tmo <= '0;
            end else if (tmo != TMAX) begin
                tmo <= tmo + TW'(1);
            end
            // an edge always beats the idle timeout
            if (mode != MODE_6B) begin
                cnt <= '0;
            end else if (selRise) begin
                cnt <= cnt + 2'd1;
            end else if (!selEdge && tmo >= TNEAR) begin
                cnt <= '0;
            end
        end
    end

    // the high half of a TH pulse already answers with the advanced phase
    always_comb begin
        cntEff = 2'd0;
        if (mode == MODE_6B) begin
            cntEff = selRise ? cnt + 2'd1 : cnt;
        end
    end

    logic bZ, bY, bX, bM, bS, bC, bB, bA, bU, bD, bL, bR;
    assign {bZ, bY, bX, bM, bS, bC, bB, bA, bU, bD, bL, bR} = btnQ;

    always_comb begin
        lvl = 6'h3F;
        unique case (mode)
            MODE_SMS: lvl = ~{bC, bB, bU, bD, bL, bR};
            MODE_3B, MODE_6B: begin
                if (sel) begin
                    if (cntEff == 2'd3) begin
                        lvl = ~{bC, bB, bZ, bY, bX, bM};
                    end else begin
                        lvl = ~{bC, bB, bU, bD, bL, bR};
                    end
                end else begin
                    case (cntEff)
                        2'd2:    lvl = {~bS, ~bA, 4'b0000};
                        2'd3:    lvl = {~bS, ~bA, 4'b1111};
                        default: lvl = {~bS, ~bA, ~bU, ~bD, 2'b00};
                    endcase
                end
            end
            MODE_OFF: lvl = 6'h3F;
        endcase
        if (iRESET) begin
            lvl = 6'h3F;
        end
    end

    assign oPAD   = lvl;
    assign oPHASE = cnt;

endmodule
